npu_job_sched: RTL and testbench
================================

Name: npu_job_sched

Overview:
- Job scheduler in front of the NPU transfer/interface controller.
- Buffers job descriptors pushed by AHB software: INIT jobs (load weight/bias/sigmoid RAMs) and RUN jobs (stream inference data).
- Issues each job to the controller in order: depth outputs, then a one-cycle init_ram/start pulse, then waits for the matching completion interrupt and acknowledges it.
- Also provides a watchdog timeout, an abort path and completion status.

Parameters:
- QDEPTH, 4, descriptor queue entries (power of 2, ≥2).
- TO_W, 24, width of the watchdog counter.
- GAP, 2, idle cycles after int_clr before the next issue (lets the controller settle in IDLE).

Ports:
- clk  in  1  clock
- hreset  in  1  async active-low reset
- sched_en  in  1  level; 0 = no new job issued (current job completes)
- job_valid  in  1  descriptor push request
- job_ready  out  1  queue not full
- job_type  in  1  0 = INIT, 1 = RUN
- job_in_depth  in  32  RUN input word count
- job_out_depth  in  32  RUN output word count
- timeout_val  in  TO_W  watchdog limit in cycles; 0 disables the watchdog
- abort  in  1  pulse: kill current job, flush queue
- err_clr  in  1  pulse: clear err
- init_ram  out  1  one-cycle INIT issue pulse
- start  out  1  one-cycle RUN issue pulse
- stop  out  1  one-cycle controller stop pulse
- int_clr  out  1  one-cycle interrupt acknowledge
- int_en_init  out  1  interrupt enable, equals sched_en
- int_en_npu  out  1  interrupt enable, equals sched_en
- npu_datain_depth  out  32  registered depth for the active RUN job
- npu_dataout_depth  out  32  registered depth for the active RUN job
- interrupt0  in  1  init-complete interrupt (level)
- interrupt1  in  1  run-complete interrupt (level)
- busy  out  1  job in flight or queue not empty
- job_done  out  1  one-cycle pulse on normal completion
- done_cnt  out  16  completed jobs, wraps at 65535→0
- err  out  1  sticky timeout flag
- q_level  out  clog2(QDEPTH)+1  current queue occupancy

Behaviour:
- Reset (hreset low, async): state IDLE; queue empty; all pulse outputs 0; depth outputs 0; done_cnt 0; err 0; job_ready 1; busy 0.
- Queue: synchronous FIFO, 65 bits per entry (type plus both depths).
  - Push when job_valid && job_ready.
  - job_ready = !full; a push while full is ignored.
  - No bypass: a push into an empty queue is poppable the next cycle.
  - Push and pop in the same cycle are both honoured; level is unchanged.
- State machine:
  - IDLE: if sched_en && !empty && !abort → LOAD (pop issued this cycle).
  - LOAD: latch the popped entry into active type/depth registers. For RUN, update npu_datain_depth/npu_dataout_depth; for INIT, depths hold their previous values. → ISSUE.
  - ISSUE: one cycle with init_ram=1 (INIT) or start=1 (RUN); clear the watchdog. → WAIT.
  - WAIT: watchdog increments each cycle.
    - interrupt0 (INIT) or interrupt1 (RUN) high → ACK.
    - The non-matching interrupt is ignored.
    - Watchdog == timeout_val with timeout_val != 0 → TOUT.
  - ACK: int_clr=1 for one cycle; job_done=1; done_cnt+1. → GAP.
  - TOUT: stop=1 for one cycle; int_clr=1 for one cycle; err←1; job dropped, done_cnt unchanged; queue retained. → GAP.
  - GAP: count GAP cycles → IDLE.
- Latency: from a queued job in IDLE with sched_en=1, the issue pulse appears 2 cycles later (IDLE→LOAD→ISSUE).
- Interrupt handling:
  - An interrupt already high on WAIT entry completes the job on that cycle's evaluation.
  - The interrupt is expected to drop within GAP cycles after int_clr.
- abort (any state other than IDLE-with-empty-queue): next cycle stop=1, queue flushed, state→IDLE. No job_done, err unchanged. abort has priority over completion and timeout in the same cycle. A push in the abort cycle is discarded.
- err_clr clears err. If err_clr coincides with a timeout, the set wins.
- sched_en=0 mid-job: the current job runs to ACK/TOUT; no new pop.
- busy = (state != IDLE) || !empty.

Decomposition:
- Shared package npu_pkg:
  - State encoding localparams.
  - JOB_INIT/JOB_RUN constants.
  - Descriptor width constant (65).
- Sub-module npu_job_fifo: parameterised sync FIFO with level output, instantiated once.

Test Plan:
1. Reset then push INIT → init_ram high on the 3rd cycle after push. Drive interrupt0 5 cycles later → int_clr pulse, job_done pulse, done_cnt=1, busy=0 after GAP.
2. Push RUN(in=16, out=8) → depth outputs 16/8 on the cycle before start. interrupt0 held high during WAIT is ignored; interrupt1 → ACK.
3. Push 4 jobs with sched_en=0 → q_level=4, job_ready=0, a 5th push is dropped. Set sched_en=1 → all 4 complete in order, done_cnt=4.
4. timeout_val=10, RUN with no interrupt → stop and int_clr pulse 10 cycles after WAIT entry, err=1, done_cnt unchanged. The next queued job then issues. err_clr → err=0.
5. abort during WAIT with 2 jobs queued → stop pulse, q_level=0, state IDLE, no job_done.
6. Assert hreset mid-WAIT → all outputs return to reset values immediately; no pulses after release until a new push.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU job scheduler.
package npu_pkg;

    localparam int   DESC_W   = 65;
    localparam logic JOB_INIT = 1'b0;
    localparam logic JOB_RUN  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ACK   = 3'd4,
        ST_TOUT  = 3'd5,
        ST_GAP   = 3'd6
    } sched_state_e;

endpackage

// File: rtl/npu_job_fifo.sv
// Synchronous descriptor FIFO with occupancy output; no write-to-read bypass.
module npu_job_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic                     clk,
    input  logic                     hreset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             wdata_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk or negedge hreset) begin
        if (!hreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/npu_job_sched.sv
// Job scheduler: queues INIT/RUN descriptors and sequences them into the NPU controller.
//   state | meaning
//   IDLE  | waiting for sched_en and a queued job (pop here)
//   LOAD  | popped descriptor held; issue pulse prepared
//   ISSUE | init_ram/start pulse visible; watchdog cleared
//   WAIT  | waiting for matching interrupt or watchdog expiry
//   ACK   | int_clr + job_done visible
//   TOUT  | stop + int_clr visible, err set
//   GAP   | settle cycles before the next issue
module npu_job_sched import npu_pkg::*; #(
    parameter int QDEPTH = 4,
    parameter int TO_W   = 24,
    parameter int GAP    = 2
) (
    input  logic                      clk,
    input  logic                      hreset,
    input  logic                      sched_en,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic                      job_type,
    input  logic [31:0]               job_in_depth,
    input  logic [31:0]               job_out_depth,
    input  logic [TO_W-1:0]           timeout_val,
    input  logic                      abort,
    input  logic                      err_clr,
    output logic                      init_ram,
    output logic                      start,
    output logic                      stop,
    output logic                      int_clr,
    output logic                      int_en_init,
    output logic                      int_en_npu,
    output logic [31:0]               npu_datain_depth,
    output logic [31:0]               npu_dataout_depth,
    input  logic                      interrupt0,
    input  logic                      interrupt1,
    output logic                      busy,
    output logic                      job_done,
    output logic [15:0]               done_cnt,
    output logic                      err,
    output logic [$clog2(QDEPTH):0]   q_level
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    sched_state_e      state_q;
    logic              act_type_q;
    logic [TO_W-1:0]   wdog_q;
    logic [TO_W-1:0]   wdog_inc;
    logic [GW-1:0]     gap_q;
    logic              init_ram_q, start_q, stop_q, int_clr_q, job_done_q, err_q;
    logic [15:0]       done_cnt_q;
    logic [31:0]       din_q, dout_q;

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, abort_act, irq_match;
    logic [DESC_W-1:0] fifo_rdata;

    // Abort is a no-op when there is nothing to kill.
    assign abort_act = abort && !(state_q == ST_IDLE && fifo_empty);
    assign fifo_push = job_valid && !abort;
    assign fifo_pop  = (state_q == ST_IDLE) && sched_en && !fifo_empty && !abort;
    assign irq_match = (act_type_q == JOB_RUN) ? interrupt1 : interrupt0;
    assign wdog_inc  = wdog_q + TO_W'(1);

    npu_job_fifo #(.DEPTH(QDEPTH), .W(DESC_W)) u_fifo (
        .clk     (clk),
        .hreset  (hreset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (abort_act),
        .wdata_i ({job_type, job_in_depth, job_out_depth}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (q_level)
    );

    always_ff @(posedge clk or negedge hreset) begin
        if (!hreset) begin
            state_q    <= ST_IDLE;
            act_type_q <= JOB_INIT;
            wdog_q     <= '0;
            gap_q      <= '0;
            init_ram_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            int_clr_q  <= 1'b0;
            job_done_q <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
            din_q      <= '0;
            dout_q     <= '0;
        end else begin
            init_ram_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            int_clr_q  <= 1'b0;
            job_done_q <= 1'b0;
            if (err_clr) err_q <= 1'b0;
            if (abort_act) begin
                stop_q  <= 1'b1;
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (fifo_pop) begin
                        act_type_q <= fifo_rdata[64];
                        if (fifo_rdata[64] == JOB_RUN) begin
                            din_q  <= fifo_rdata[63:32];
                            dout_q <= fifo_rdata[31:0];
                        end
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        init_ram_q <= (act_type_q == JOB_INIT);
                        start_q    <= (act_type_q == JOB_RUN);
                        state_q    <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        wdog_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (irq_match) begin
                            int_clr_q  <= 1'b1;
                            job_done_q <= 1'b1;
                            done_cnt_q <= done_cnt_q + 16'd1;
                            state_q    <= ST_ACK;
                        end else if (timeout_val != '0 && wdog_inc == timeout_val) begin
                            stop_q    <= 1'b1;
                            int_clr_q <= 1'b1;
                            err_q     <= 1'b1;
                            state_q   <= ST_TOUT;
                        end else begin
                            wdog_q <= wdog_inc;
                        end
                    end
                    ST_ACK, ST_TOUT: begin
                        gap_q   <= GW'(GAP - 1);
                        state_q <= ST_GAP;
                    end
                    ST_GAP: begin
                        if (gap_q == '0) state_q <= ST_IDLE;
                        else             gap_q   <= gap_q - GW'(1);
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign job_ready         = !fifo_full;
    assign busy              = (state_q != ST_IDLE) || !fifo_empty;
    assign int_en_init       = sched_en;
    assign int_en_npu        = sched_en;
    assign init_ram          = init_ram_q;
    assign start             = start_q;
    assign stop              = stop_q;
    assign int_clr           = int_clr_q;
    assign job_done          = job_done_q;
    assign err               = err_q;
    assign done_cnt          = done_cnt_q;
    assign npu_datain_depth  = din_q;
    assign npu_dataout_depth = dout_q;

endmodule

// File: tb/tb_npu_job_sched.sv
// Self-checking bench for npu_job_sched: directed corner cases plus a randomized job stream.
module tb_npu_job_sched;
    import npu_pkg::*;

    localparam int QDEPTH = 4;
    localparam int TO_W   = 24;
    localparam int GAP    = 2;

    logic clk = 1'b0, hreset = 1'b0, sched_en = 1'b0, job_valid = 1'b0, job_type = 1'b0;
    logic abort = 1'b0, err_clr = 1'b0, interrupt0 = 1'b0, interrupt1 = 1'b0;
    logic [31:0] job_in_depth = '0, job_out_depth = '0;
    logic [TO_W-1:0] timeout_val = '0;
    logic job_ready, init_ram, start, stop, int_clr, int_en_init, int_en_npu, busy, job_done, err;
    logic [31:0] npu_datain_depth, npu_dataout_depth;
    logic [15:0] done_cnt;
    logic [$clog2(QDEPTH):0] q_level;

    int checks = 0, failures = 0;

    npu_job_sched #(.QDEPTH(QDEPTH), .TO_W(TO_W), .GAP(GAP)) dut (
        .clk(clk), .hreset(hreset), .sched_en(sched_en), .job_valid(job_valid),
        .job_ready(job_ready), .job_type(job_type), .job_in_depth(job_in_depth),
        .job_out_depth(job_out_depth), .timeout_val(timeout_val), .abort(abort),
        .err_clr(err_clr), .init_ram(init_ram), .start(start), .stop(stop),
        .int_clr(int_clr), .int_en_init(int_en_init), .int_en_npu(int_en_npu),
        .npu_datain_depth(npu_datain_depth), .npu_dataout_depth(npu_dataout_depth),
        .interrupt0(interrupt0), .interrupt1(interrupt1), .busy(busy),
        .job_done(job_done), .done_cnt(done_cnt), .err(err), .q_level(q_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        typ;
        logic [31:0] din;
        logic [31:0] dout;
    } desc_t;

    typedef struct {
        logic        typ;
        logic [31:0] din;
        logic [31:0] dout;
        bit          acc;
        int          exp_level;
        logic        exp_ready;
    } vec_t;

    // Reference model: ordered list of jobs pushed but not yet issued, plus expected status.
    desc_t       model_q[$];
    logic [31:0] last_din = '0, last_dout = '0;
    logic [15:0] exp_done = '0;
    logic        exp_err = 1'b0;
    bit          inflight = 0, due_to = 0, irq_typ = 0;
    int          due = 0, irq_at = 0, cyc = 0, resp_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic t, input logic [31:0] i, input logic [31:0] o);
        job_valid = 1'b1; job_type = t; job_in_depth = i; job_out_depth = o;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, job_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_level"}, q_level, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_pulses"}, {init_ram, start, stop, int_clr, job_done}, 0);
        chk({tag, "_depths"}, {npu_datain_depth, npu_dataout_depth}, 0);
    endtask

    task automatic wait_for(input string name, input int bound, input bit want_ack);
        int n = 0;
        while (!(want_ack ? int_clr : (init_ram || start)) && n < bound) begin
            tick();
            n++;
        end
        checks++;
        if (!(want_ack ? int_clr : (init_ram || start))) begin
            failures++;
            $display("FAIL %s: expected pulse absent after %0d cycles", name, bound);
        end
    endtask

    // One cycle of the model-driven controller emulation; called at posedge+1.
    task automatic engine_cycle(input bit allow_push);
        desc_t d;
        bit ack_now;
        chk("int_en", {int_en_init, int_en_npu}, {sched_en, sched_en});
        if (init_ram || start) begin
            checks++;
            if (model_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got issue pulse, expected none");
            end else begin
                d = model_q.pop_front();
                chk("issue_kind", {init_ram, start}, (d.typ == JOB_RUN) ? 2'b01 : 2'b10);
                if (d.typ == JOB_RUN) begin
                    last_din = d.din;
                    last_dout = d.dout;
                end
                chk("issue_din", npu_datain_depth, last_din);
                chk("issue_dout", npu_dataout_depth, last_dout);
                inflight = 1; irq_typ = d.typ;
                if (resp_mode == 1 && $urandom_range(0, 3) == 0) begin
                    due_to = 1;
                    due = cyc + int'(timeout_val) + 1;
                end else begin
                    due_to = 0;
                    irq_at = cyc + ((resp_mode == 1) ? int'($urandom_range(1, 8)) : 1);
                    due = irq_at + 1;
                end
            end
        end
        ack_now = inflight && (cyc == due);
        chk("int_clr", int_clr, ack_now);
        chk("stop", stop, ack_now && due_to);
        chk("job_done", job_done, ack_now && !due_to);
        if (ack_now) begin
            if (due_to) exp_err = 1'b1;
            else        exp_done = exp_done + 16'd1;
            chk("done_cnt", done_cnt, exp_done);
            chk("err", err, exp_err);
            interrupt0 = 1'b0; interrupt1 = 1'b0; inflight = 0;
        end
        if (inflight && !due_to && cyc == irq_at) begin
            if (irq_typ) interrupt1 = 1'b1;
            else         interrupt0 = 1'b1;
        end
        job_valid = 1'b0;
        if (allow_push) begin
            if ($urandom_range(0, 15) == 0) sched_en = !sched_en;
            if (model_q.size() < QDEPTH && $urandom_range(0, 2) == 0) begin
                d.typ = $urandom_range(0, 1) == 1;
                d.din = $urandom;
                d.dout = $urandom;
                chk("job_ready", job_ready, 1);
                model_q.push_back(d);
                job_valid = 1'b1; job_type = d.typ; job_in_depth = d.din; job_out_depth = d.dout;
            end
        end
        tick();
        cyc++;
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((model_q.size() > 0 || inflight || busy) && n < bound) begin
            engine_cycle(0);
            n++;
        end
        checks++;
        if (model_q.size() > 0 || inflight || busy) begin
            failures++;
            $display("FAIL %s: still busy after %0d cycles", name, bound);
        end
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{JOB_INIT, 32'd0, 32'd0, 1, 1, 1'b1};
        vecs[1] = '{JOB_RUN,  32'd1, 32'd2, 1, 2, 1'b1};
        vecs[2] = '{JOB_RUN,  32'd3, 32'd4, 1, 3, 1'b1};
        vecs[3] = '{JOB_INIT, 32'd0, 32'd0, 1, 4, 1'b0};
        vecs[4] = '{JOB_RUN,  32'd5, 32'd6, 0, 4, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        hreset = 1'b1;
        sched_en = 1'b1;
        tick();

        // INIT job: issue latency, completion, gap
        push(JOB_INIT, 32'd0, 32'd0);
        chk("t1_busy", busy, 1);
        chk("t1_c1", init_ram, 0);
        tick(); chk("t1_c2", init_ram, 0);
        tick(); chk("t1_c3", {init_ram, start}, 2'b10);
        repeat (5) tick();
        interrupt0 = 1'b1;
        tick();
        chk("t1_ack", {int_clr, job_done, stop}, 3'b110);
        chk("t1_cnt", done_cnt, 1);
        interrupt0 = 1'b0;
        tick(); chk("t1_pulse_len", {int_clr, job_done}, 0);
        chk("t1_busy_gap", busy, 1);
        repeat (2) tick();
        chk("t1_idle", busy, 0);

        // RUN job: depths before start, non-matching interrupt ignored
        push(JOB_RUN, 32'd16, 32'd8);
        tick();
        chk("t2_depths", {npu_datain_depth, npu_dataout_depth}, {32'd16, 32'd8});
        chk("t2_pre_start", start, 0);
        tick(); chk("t2_start", {init_ram, start}, 2'b01);
        interrupt0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t2_ignore_irq0", int_clr, 0);
        end
        interrupt1 = 1'b1;
        tick();
        chk("t2_ack", {int_clr, job_done}, 2'b11);
        chk("t2_cnt", done_cnt, 2);
        interrupt0 = 1'b0; interrupt1 = 1'b0;
        repeat (3) tick();
        chk("t2_idle", busy, 0);
        last_din = 32'd16; last_dout = 32'd8; exp_done = 16'd2;

        // Fill queue with scheduling disabled, then drain in order
        sched_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].typ, vecs[i].din, vecs[i].dout);
            chk("t3_level", q_level, vecs[i].exp_level);
            chk("t3_ready", job_ready, vecs[i].exp_ready);
            chk("t3_busy", busy, 1);
            if (vecs[i].acc) model_q.push_back('{vecs[i].typ, vecs[i].din, vecs[i].dout});
        end
        sched_en = 1'b1;
        resp_mode = 0;
        drain("t3_drain", 300);
        chk("t3_done_cnt", done_cnt, 6);

        // Watchdog timeout, err set beats coincident err_clr, queue retained
        timeout_val = 24'd10;
        push(JOB_RUN, 32'd7, 32'd9);
        push(JOB_INIT, 32'd0, 32'd0);
        chk("t4_depths", {npu_datain_depth, npu_dataout_depth}, {32'd7, 32'd9});
        tick(); chk("t4_start", start, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_no_stop", stop, 0);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_tout", {stop, int_clr, job_done}, 3'b110);
        chk("t4_err", err, 1);
        chk("t4_cnt", done_cnt, 6);
        chk("t4_level", q_level, 1);
        wait_for("t4_next_issue", 10, 0);
        chk("t4_next_kind", {init_ram, start}, 2'b10);
        chk("t4_init_depths", {npu_datain_depth, npu_dataout_depth}, {32'd7, 32'd9});
        interrupt0 = 1'b1;
        wait_for("t4_ack", 5, 1);
        chk("t4_ack_done", job_done, 1);
        chk("t4_ack_cnt", done_cnt, 7);
        chk("t4_err_sticky", err, 1);
        interrupt0 = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_err_clr", err, 0);
        repeat (4) tick();

        // Abort during WAIT, with competing completion and push
        timeout_val = '0;
        sched_en = 1'b0;
        push(JOB_RUN, 32'd11, 32'd12);
        push(JOB_RUN, 32'd13, 32'd14);
        push(JOB_INIT, 32'd0, 32'd0);
        chk("t5_level3", q_level, 3);
        sched_en = 1'b1;
        wait_for("t5_issue", 6, 0);
        chk("t5_level2", q_level, 2);
        repeat (2) tick();
        abort = 1'b1; interrupt1 = 1'b1;
        job_valid = 1'b1; job_type = JOB_RUN;
        tick();
        abort = 1'b0; interrupt1 = 1'b0; job_valid = 1'b0;
        chk("t5_stop", {stop, int_clr, job_done}, 3'b100);
        chk("t5_level0", q_level, 0);
        chk("t5_idle", busy, 0);
        chk("t5_cnt", done_cnt, 7);
        chk("t5_err", err, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_quiet", {init_ram, start, stop, int_clr, job_done, busy}, 0);
        end

        // Asynchronous reset mid-WAIT
        push(JOB_RUN, 32'd21, 32'd22);
        push(JOB_INIT, 32'd0, 32'd0);
        wait_for("t6_issue", 6, 0);
        repeat (2) tick();
        hreset = 1'b0;
        #1;
        chk_reset("t6");
        @(posedge clk);
        #1;
        hreset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_quiet", {init_ram, start, stop, int_clr, job_done, busy}, 0);
        end

        // Randomized stream against the model
        model_q.delete();
        inflight = 0; exp_done = '0; exp_err = 1'b0; last_din = '0; last_dout = '0;
        timeout_val = 24'd10;
        resp_mode = 1;
        sched_en = 1'b1;
        for (int n = 0; n < 3000; n++) engine_cycle(1);
        sched_en = 1'b1;
        drain("rand_drain", 1000);
        chk("rand_done_cnt", done_cnt, exp_done);
        chk("rand_err", err, exp_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
